// File: rtl/program_load_sequencer_pkg.sv
// Shared definitions for the program-load sequencer: FSM states, session
// status codes and the per-word address stride.
package program_load_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_DONE
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t STAT_HALT   = 2'b00;
  localparam status_t STAT_BUDGET = 2'b01;
  localparam status_t STAT_ABORT  = 2'b10;
  localparam status_t STAT_PARAM  = 2'b11;

  localparam int WORD_INC = 4;

endpackage

// File: rtl/program_load_sequencer_run_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear and a budget-hit flag
// that fires in the cycle whose increment reaches a nonzero budget.
module run_cycle_counter #(
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CYC_W-1:0] budget,
  output logic [CYC_W-1:0] count,
  output logic             budget_hit
);

  logic [CYC_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero budget means unlimited, so it never produces a hit.
  assign budget_hit = (budget != '0) && ((count_q + CYC_W'(1)) == budget);
  assign count      = count_q;

endmodule

// File: rtl/program_load_sequencer.sv
// Session controller in front of data_path: holds the core in reset, streams
// host words into instruction memory, runs the core, then freezes it again.
module program_load_sequencer
  import program_load_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic              ip_clk,
  input  logic              ip_rst,
  input  logic              ip_start,
  input  logic [ADDR_W-1:0] ip_base_addr,
  input  logic [CNT_W-1:0]  ip_instr_count,
  input  logic [CYC_W-1:0]  ip_run_cycles,
  input  logic [DATA_W-1:0] ip_host_data,
  input  logic              ip_host_valid,
  output logic              op_host_ready,
  input  logic              ip_halt,
  input  logic              ip_abort,
  output logic [DATA_W-1:0] op_wr_instr_mem_data,
  output logic [ADDR_W-1:0] op_wr_instr_mem_addr,
  output logic              op_wr_instr_mem_en,
  output logic              op_stall_ctrl,
  output logic              op_core_rst,
  output logic              op_busy,
  output logic              op_done,
  output logic [1:0]        op_status,
  output logic [CYC_W-1:0]  op_cycle_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [CYC_W-1:0]  budget_q, budget_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              stall_q, stall_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  status_t           status_q, status_d;
  logic              cnt_clr;
  logic              budget_hit;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    budget_d   = budget_q;
    rst_cnt_d  = rst_cnt_q;
    ready_d    = ready_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    stall_d    = stall_q;
    core_rst_d = core_rst_q;
    busy_d     = busy_q;
    done_d     = done_q;
    status_d   = status_q;
    cnt_clr    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ip_start) begin
          cnt_clr  = 1'b1;
          addr_d   = ip_base_addr;
          remain_d = ip_instr_count;
          budget_d = ip_run_cycles;
          stall_d  = 1'b1;
          // A rejected session keeps the core held in reset throughout.
          core_rst_d = 1'b1;
          if ((ip_base_addr[1:0] != 2'b00) || (ip_instr_count == '0)) begin
            state_d  = S_DONE;
            status_d = STAT_PARAM;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            state_d   = S_CORE_RST;
            status_d  = STAT_HALT;
            done_d    = 1'b0;
            busy_d    = 1'b1;
            rst_cnt_d = '0;
          end
        end
      end
      S_CORE_RST: begin
        if (ip_abort) begin
          state_d    = S_DONE;
          status_d   = STAT_ABORT;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          core_rst_d = 1'b0;
        end else if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d    = S_LOAD;
          core_rst_d = 1'b0;
          ready_d    = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_LOAD: begin
        if (ip_abort) begin
          // Any handshake in this cycle is dropped on the floor.
          state_d  = S_DONE;
          status_d = STAT_ABORT;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          ready_d  = 1'b0;
        end else if (ready_q && ip_host_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = ip_host_data;
          wr_addr_d = addr_q;
          addr_d    = addr_q + ADDR_W'(WORD_INC);
          remain_d  = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            ready_d = 1'b0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_RUN;
        stall_d = 1'b0;
      end
      S_RUN: begin
        if (ip_abort || ip_halt || budget_hit) begin
          state_d  = S_DONE;
          stall_d  = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          status_d = ip_abort ? STAT_ABORT : (ip_halt ? STAT_HALT : STAT_BUDGET);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ip_clk or negedge ip_rst) begin
    if (!ip_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      budget_q   <= '0;
      rst_cnt_q  <= '0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      stall_q    <= 1'b1;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= STAT_HALT;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      budget_q   <= budget_d;
      rst_cnt_q  <= rst_cnt_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      stall_q    <= stall_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
    end
  end

  run_cycle_counter #(
    .CYC_W (CYC_W)
  ) u_run_cycle_counter (
    .clk        (ip_clk),
    .rst_n      (ip_rst),
    .clr        (cnt_clr),
    .en         (state_q == S_RUN),
    .budget     (budget_q),
    .count      (op_cycle_count),
    .budget_hit (budget_hit)
  );

  assign op_host_ready        = ready_q;
  assign op_wr_instr_mem_data = wr_data_q;
  assign op_wr_instr_mem_addr = wr_addr_q;
  assign op_wr_instr_mem_en   = wr_en_q;
  assign op_stall_ctrl        = stall_q;
  assign op_core_rst          = core_rst_q;
  assign op_busy              = busy_q;
  assign op_done              = done_q;
  assign op_status            = status_q;

endmodule

// File: tb/tb_program_load_sequencer.sv
// Self-checking bench for program_load_sequencer: directed sessions plus
// randomized ones scored against a session-level reference model.
module tb_program_load_sequencer;

  logic        ip_clk = 1'b0;
  logic        ip_rst = 1'b0;
  logic        ip_start = 1'b0;
  logic [31:0] ip_base_addr = '0;
  logic [15:0] ip_instr_count = '0;
  logic [31:0] ip_run_cycles = '0;
  logic [31:0] ip_host_data = '0;
  logic        ip_host_valid = 1'b0;
  logic        op_host_ready;
  logic        ip_halt = 1'b0;
  logic        ip_abort = 1'b0;
  logic [31:0] op_wr_instr_mem_data;
  logic [31:0] op_wr_instr_mem_addr;
  logic        op_wr_instr_mem_en;
  logic        op_stall_ctrl;
  logic        op_core_rst;
  logic        op_busy;
  logic        op_done;
  logic [1:0]  op_status;
  logic [31:0] op_cycle_count;

  program_load_sequencer dut (
    .ip_clk               (ip_clk),
    .ip_rst               (ip_rst),
    .ip_start             (ip_start),
    .ip_base_addr         (ip_base_addr),
    .ip_instr_count       (ip_instr_count),
    .ip_run_cycles        (ip_run_cycles),
    .ip_host_data         (ip_host_data),
    .ip_host_valid        (ip_host_valid),
    .op_host_ready        (op_host_ready),
    .ip_halt              (ip_halt),
    .ip_abort             (ip_abort),
    .op_wr_instr_mem_data (op_wr_instr_mem_data),
    .op_wr_instr_mem_addr (op_wr_instr_mem_addr),
    .op_wr_instr_mem_en   (op_wr_instr_mem_en),
    .op_stall_ctrl        (op_stall_ctrl),
    .op_core_rst          (op_core_rst),
    .op_busy              (op_busy),
    .op_done              (op_done),
    .op_status            (op_status),
    .op_cycle_count       (op_cycle_count)
  );

  always #5 ip_clk = ~ip_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] words [8];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          stall_low_cnt = 0;
  int          core_rst_low_cnt = 0;
  int          cyc = 0;

  // Observer: records every presented write and counts released cycles.
  always @(negedge ip_clk) begin
    cyc = cyc + 1;
    if (ip_rst) begin
      if (op_wr_instr_mem_en) begin
        wr_addr_q.push_back(op_wr_instr_mem_addr);
        wr_data_q.push_back(op_wr_instr_mem_data);
        wr_cyc_q.push_back(cyc);
      end
      if (!op_stall_ctrl) stall_low_cnt = stall_low_cnt + 1;
      if (!op_core_rst) core_rst_low_cnt = core_rst_low_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ip_clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    stall_low_cnt = 0;
    core_rst_low_cnt = 0;
  endtask

  task automatic do_reset();
    ip_rst = 1'b0;
    ip_start = 1'b0;
    ip_host_valid = 1'b0;
    ip_halt = 1'b0;
    ip_abort = 1'b0;
    repeat (2) @(posedge ip_clk);
    #1;
    ip_rst = 1'b1;
    clear_obs();
  endtask

  task automatic fill_words(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  task automatic start_session(input logic [31:0] base, input logic [15:0] cnt,
                               input logic [31:0] bud);
    clear_obs();
    ip_base_addr = base;
    ip_instr_count = cnt;
    ip_run_cycles = bud;
    ip_start = 1'b1;
    tick();
    ip_start = 1'b0;
  endtask

  // mode 0: valid always, 1: alternating 1,0,..., 2: random.
  // abort_after > 0 raises abort (with a word offered) once that many were taken.
  task automatic load_words(input int n, input int mode, input int abort_after,
                            output int accepted, output bit ready_drop);
    int  phase = 0;
    bit  seen = 0;
    bit  v;
    bit  hs;
    accepted = 0;
    ready_drop = 0;
    for (int c = 0; c < 300 && accepted < n; c++) begin
      if (seen && !op_host_ready) ready_drop = 1;
      if (op_host_ready) seen = 1;
      if (abort_after > 0 && accepted == abort_after) begin
        ip_abort = 1'b1;
        ip_host_valid = 1'b1;
        ip_host_data = words[accepted];
        tick();
        ip_abort = 1'b0;
        ip_host_valid = 1'b0;
        return;
      end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 2 == 0) : 1'($urandom_range(0, 1));
      if (op_host_ready) phase++;
      ip_host_valid = v;
      ip_host_data = v ? words[accepted] : 32'hDEAD_BEEF;
      hs = v && op_host_ready;
      tick();
      if (hs) accepted++;
    end
    ip_host_valid = 1'b0;
  endtask

  task automatic wait_run(input int halt_at, input int abort_at,
                          output int pre, output int run, output bit to);
    pre = 0;
    run = 0;
    to = 0;
    while (op_stall_ctrl && pre < 100) begin
      tick();
      pre++;
    end
    if (op_stall_ctrl) begin
      to = 1;
      return;
    end
    while (!op_stall_ctrl && run < 5000) begin
      run++;
      ip_halt = (run == halt_at);
      ip_abort = (run == abort_at);
      tick();
    end
    ip_halt = 1'b0;
    ip_abort = 1'b0;
    if (!op_stall_ctrl) to = 1;
  endtask

  task automatic test_reset();
    ip_rst = 1'b0;
    repeat (2) @(posedge ip_clk);
    #1;
    n_checks++;
    if ({op_stall_ctrl, op_core_rst, op_wr_instr_mem_en, op_host_ready, op_busy, op_done, op_status} !== 8'b1100_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 11000000", {op_stall_ctrl, op_core_rst, op_wr_instr_mem_en, op_host_ready, op_busy, op_done, op_status});
    end
    n_checks++;
    if ({op_wr_instr_mem_data, op_wr_instr_mem_addr, op_cycle_count} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h want 0", op_wr_instr_mem_data, op_wr_instr_mem_addr, op_cycle_count);
    end
    ip_rst = 1'b1;
    tick();
    n_checks++;
    if ({op_stall_ctrl, op_core_rst, op_busy, op_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 1100", {op_stall_ctrl, op_core_rst, op_busy, op_done});
    end
  endtask

  task automatic test_basic_load_halt();
    int acc, pre, run;
    bit drop, to;
    words[0] = 32'h020002B7;
    words[1] = 32'h0002A303;
    words[2] = 32'h0042A383;
    start_session(32'h8000, 16'd3, 32'd0);
    n_checks++;
    if ({op_busy, op_done, op_core_rst, op_stall_ctrl} !== 4'b1011) begin
      n_fail++;
      $display("FAIL t1_start got %b want 1011", {op_busy, op_done, op_core_rst, op_stall_ctrl});
    end
    load_words(3, 0, 0, acc, drop);
    n_checks++;
    if (op_host_ready !== 1'b0 || op_stall_ctrl !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_drain got ready=%b stall=%b want 0 1", op_host_ready, op_stall_ctrl);
    end
    wait_run(10, 0, pre, run, to);
    n_checks++;
    if (to || pre != 1) begin
      n_fail++;
      $display("FAIL t1_release got pre=%0d to=%0d want 1 0", pre, to);
    end
    n_checks++;
    if (wr_addr_q.size() != 3) begin
      n_fail++;
      $display("FAIL t1_nwrites got %0d want 3", wr_addr_q.size());
    end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 32'h8000 + 32'(4 * i) || wr_data_q[i] !== words[i]) begin
        n_fail++;
        $display("FAIL t1_write%0d got %h:%h want %h:%h", i, wr_addr_q[i], wr_data_q[i], 32'h8000 + 32'(4 * i), words[i]);
      end
    end
    n_checks++;
    if (wr_cyc_q.size() == 3 && (wr_cyc_q[2] - wr_cyc_q[0]) != 2) begin
      n_fail++;
      $display("FAIL t1_consecutive got span %0d want 2", wr_cyc_q[2] - wr_cyc_q[0]);
    end
    n_checks++;
    if ({op_done, op_busy, op_status, op_core_rst} !== 5'b10000 || op_cycle_count !== 32'd10 || stall_low_cnt != 10) begin
      n_fail++;
      $display("FAIL t1_end got done=%b busy=%b st=%b crst=%b cnt=%0d low=%0d want 1 0 00 0 10 10",
               op_done, op_busy, op_status, op_core_rst, op_cycle_count, stall_low_cnt);
    end
  endtask

  task automatic test_valid_gaps();
    int acc, pre, run;
    bit drop, to;
    fill_words(4);
    start_session(32'h0000_1000, 16'd4, 32'd2);
    ip_halt = 1'b1;
    load_words(4, 1, 0, acc, drop);
    ip_halt = 1'b0;
    n_checks++;
    if (drop || acc != 4) begin
      n_fail++;
      $display("FAIL t2_ready got drop=%0d acc=%0d want 0 4", drop, acc);
    end
    wait_run(0, 0, pre, run, to);
    n_checks++;
    if (wr_addr_q.size() != 4) begin
      n_fail++;
      $display("FAIL t2_nwrites got %0d want 4", wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 32'h1000 + 32'(4 * i) || wr_data_q[i] !== words[i]
          || (i > 0 && wr_cyc_q[i] - wr_cyc_q[i-1] != 2)) begin
        n_fail++;
        $display("FAIL t2_write%0d got %h:%h want %h:%h gap 2", i, wr_addr_q[i], wr_data_q[i], 32'h1000 + 32'(4 * i), words[i]);
      end
    end
    n_checks++;
    if (to || op_status !== 2'b01 || op_cycle_count !== 32'd2) begin
      n_fail++;
      $display("FAIL t2_end got st=%b cnt=%0d to=%0d want 01 2 0", op_status, op_cycle_count, to);
    end
  endtask

  task automatic test_budget();
    int acc, pre, run;
    bit drop, to;
    fill_words(2);
    start_session(32'h0000_0200, 16'd2, 32'd5);
    ip_start = 1'b1;
    ip_base_addr = 32'h0000_4000;
    load_words(2, 0, 0, acc, drop);
    ip_start = 1'b0;
    wait_run(0, 0, pre, run, to);
    n_checks++;
    if (to || run != 5 || stall_low_cnt != 5) begin
      n_fail++;
      $display("FAIL t3_stall_low got run=%0d low=%0d to=%0d want 5 5 0", run, stall_low_cnt, to);
    end
    n_checks++;
    if (op_status !== 2'b01 || op_cycle_count !== 32'd5 || op_done !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_end got st=%b cnt=%0d done=%b want 01 5 1", op_status, op_cycle_count, op_done);
    end
    n_checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 32'h200) begin
      n_fail++;
      $display("FAIL t3_busy_start got n=%0d a0=%h want 2 00000200", wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hx);
    end
  endtask

  task automatic test_param_error();
    do_reset();
    start_session(32'h8002, 16'd3, 32'd0);
    n_checks++;
    if ({op_done, op_busy, op_status, op_core_rst, op_stall_ctrl, op_wr_instr_mem_en} !== 7'b1011110) begin
      n_fail++;
      $display("FAIL t4_misaligned got %b want 1011110", {op_done, op_busy, op_status, op_core_rst, op_stall_ctrl, op_wr_instr_mem_en});
    end
    repeat (3) tick();
    start_session(32'h8000, 16'd0, 32'd0);
    n_checks++;
    if ({op_done, op_busy, op_status, op_core_rst, op_stall_ctrl, op_wr_instr_mem_en} !== 7'b1011110) begin
      n_fail++;
      $display("FAIL t4_zero_count got %b want 1011110", {op_done, op_busy, op_status, op_core_rst, op_stall_ctrl, op_wr_instr_mem_en});
    end
    repeat (3) tick();
    n_checks++;
    if (stall_low_cnt != 0 || core_rst_low_cnt != 0 || wr_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL t4_held got low=%0d crst_low=%0d writes=%0d want 0 0 0", stall_low_cnt, core_rst_low_cnt, wr_addr_q.size());
    end
  endtask

  task automatic test_abort();
    int acc, pre, run;
    bit drop, to;
    fill_words(5);
    start_session(32'h0000_3000, 16'd5, 32'd0);
    load_words(5, 0, 2, acc, drop);
    tick();
    n_checks++;
    if (wr_addr_q.size() != 2 || op_status !== 2'b10 || op_done !== 1'b1 || stall_low_cnt != 0) begin
      n_fail++;
      $display("FAIL t5_load_abort got writes=%0d st=%b done=%b low=%0d want 2 10 1 0", wr_addr_q.size(), op_status, op_done, stall_low_cnt);
    end
    fill_words(1);
    start_session(32'h0, 16'd1, 32'd3);
    load_words(1, 0, 0, acc, drop);
    wait_run(3, 3, pre, run, to);
    n_checks++;
    if (to || op_status !== 2'b10 || op_cycle_count !== 32'd3) begin
      n_fail++;
      $display("FAIL t5_same_cycle got st=%b cnt=%0d to=%0d want 10 3 0", op_status, op_cycle_count, to);
    end
  endtask

  task automatic test_reset_and_wrap();
    int acc, pre, run;
    bit drop, to;
    fill_words(4);
    start_session(32'h0000_0100, 16'd4, 32'd0);
    load_words(2, 0, 0, acc, drop);
    #2;
    ip_rst = 1'b0;
    #1;
    n_checks++;
    if ({op_stall_ctrl, op_core_rst, op_wr_instr_mem_en, op_host_ready, op_busy, op_done, op_status} !== 8'b1100_0000
        || {op_wr_instr_mem_data, op_wr_instr_mem_addr, op_cycle_count} !== 96'd0) begin
      n_fail++;
      $display("FAIL t6_async_reset got %b %h %h want 11000000 0 0",
               {op_stall_ctrl, op_core_rst, op_wr_instr_mem_en, op_host_ready, op_busy, op_done, op_status},
               op_wr_instr_mem_addr, op_cycle_count);
    end
    tick();
    ip_rst = 1'b1;
    tick();
    fill_words(2);
    start_session(32'hFFFF_FFFC, 16'd2, 32'd3);
    load_words(2, 0, 0, acc, drop);
    wait_run(0, 0, pre, run, to);
    n_checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 32'hFFFF_FFFC || wr_addr_q[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL t6_wrap got n=%0d want FFFFFFFC then 00000000", wr_addr_q.size());
    end
    n_checks++;
    if (to || op_status !== 2'b01 || op_cycle_count !== 32'd3) begin
      n_fail++;
      $display("FAIL t6_wrap_end got st=%b cnt=%0d want 01 3", op_status, op_cycle_count);
    end
  endtask

  task automatic test_random();
    int acc, pre, run, n, halt_at, exp_cyc;
    bit drop, to;
    logic [31:0] base, bud;
    logic [1:0] exp_st;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      base = {$urandom, 2'b00};
      bud = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      halt_at = $urandom_range(1, 15);
      fill_words(n);
      // Reference: the run ends at the earlier of halt and budget; halt wins a tie.
      if (bud == 0 || halt_at <= int'(bud)) begin
        exp_cyc = halt_at;
        exp_st = 2'b00;
      end else begin
        exp_cyc = int'(bud);
        exp_st = 2'b01;
      end
      start_session(base, 16'(n), bud);
      load_words(n, 2, 0, acc, drop);
      wait_run(halt_at, 0, pre, run, to);
      n_checks++;
      if (wr_addr_q.size() != n) begin
        n_fail++;
        $display("FAIL rnd%0d_nwrites got %0d want %0d", it, wr_addr_q.size(), n);
      end
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
        n_checks++;
        if (wr_addr_q[i] !== base + 32'(4 * i) || wr_data_q[i] !== words[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_write%0d got %h:%h want %h:%h", it, i, wr_addr_q[i], wr_data_q[i], base + 32'(4 * i), words[i]);
        end
      end
      n_checks++;
      if (to || op_status !== exp_st || op_cycle_count !== 32'(exp_cyc) || stall_low_cnt != exp_cyc) begin
        n_fail++;
        $display("FAIL rnd%0d_end got st=%b cnt=%0d low=%0d want %b %0d", it, op_status, op_cycle_count, stall_low_cnt, exp_st, exp_cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load_halt();
    test_valid_gaps();
    test_budget();
    test_param_error();
    test_abort();
    test_reset_and_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
